// File: rtl/intr_ctrl_if.sv
// rtl/intr_ctrl_if.sv - interrupt controller signal bundle with master/slave views
interface intr_ctrl_if #(
  parameter int N_IRQ = 8
);
  localparam int ID_W = $clog2(N_IRQ);

  logic [N_IRQ-1:0] irq_in;
  logic             mask_we;
  logic [N_IRQ-1:0] mask_wdata;
  logic             clr_we;
  logic [N_IRQ-1:0] clr_data;
  logic             ir_ack;
  logic             eret;
  logic             ir_req;
  logic [ID_W-1:0]  ir_id;
  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] mask;
  logic             busy;

  // Controller side: receives lines, register writes and CP0 strobes
  modport slave (
    input  irq_in, mask_we, mask_wdata, clr_we, clr_data, ir_ack, eret,
    output ir_req, ir_id, pending, mask, busy
  );

  // CPU/environment side: drives lines, register writes and CP0 strobes
  modport master (
    output irq_in, mask_we, mask_wdata, clr_we, clr_data, ir_ack, eret,
    input  ir_req, ir_id, pending, mask, busy
  );
endinterface

// File: rtl/intr_ctrl.sv
// rtl/intr_ctrl.sv - edge-triggered prioritised interrupt controller; INTR_SYNC_EN adds a 2-flop input synchronizer
module intr_ctrl #(
  parameter int N_IRQ = 8
) (
  input  logic      clk,
  input  logic      rst,
  intr_ctrl_if.slave bus
);
  localparam int ID_W = $clog2(N_IRQ);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] SERVICE = 2'd2;

  logic [1:0]       state;
  logic [N_IRQ-1:0] smp;
  logic [N_IRQ-1:0] prev;
  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] pending_q;
  logic [N_IRQ-1:0] mask_q;
  logic [N_IRQ-1:0] cand;
  logic [N_IRQ-1:0] clr_bits;
  logic [ID_W-1:0]  sel;
  logic [ID_W-1:0]  ir_id_q;
  logic             ir_req_q;
  logic             ack_take;

`ifdef INTR_SYNC_EN
  logic [N_IRQ-1:0] sync1;
  logic [N_IRQ-1:0] sync2;

  // Two-flop synchronizer for the asynchronous interrupt lines
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= bus.irq_in;
      sync2 <= sync1;
    end
  end

  assign smp = sync2;
`else
  logic [N_IRQ-1:0] smp_q;

  // Single sampling flop; lines are assumed already clean
  always_ff @(posedge clk or posedge rst) begin
    if (rst) smp_q <= '0;
    else     smp_q <= bus.irq_in;
  end

  assign smp = smp_q;
`endif

  // Previous sampled level for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= '0;
    else     prev <= smp;
  end

  assign rise     = smp & ~prev;
  assign cand     = pending_q & mask_q;
  assign ack_take = (state == REQ) && bus.ir_ack;
  assign clr_bits = (bus.clr_we ? bus.clr_data : '0)
                  | (ack_take ? (N_IRQ'(1) << ir_id_q) : '0);

  // Lowest-index candidate wins
  always_comb begin
    sel = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (cand[i]) sel = ID_W'(i);
    end
  end

  // Pending register: a newly detected edge overrides a same-cycle clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending_q <= '0;
    else     pending_q <= (pending_q & ~clr_bits) | rise;
  end

  // Mask register; arbitration sees a write from the following cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              mask_q <= '0;
    else if (bus.mask_we) mask_q <= bus.mask_wdata;
  end

  // Request FSM: no nesting, request withdrawn if its source disappears
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ir_req_q <= 1'b0;
      ir_id_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cand != '0) begin
            state    <= REQ;
            ir_req_q <= 1'b1;
            ir_id_q  <= sel;
          end
        end
        REQ: begin
          if (bus.ir_ack) begin
            state    <= SERVICE;
            ir_req_q <= 1'b0;
          end else if (!cand[ir_id_q]) begin
            state    <= IDLE;
            ir_req_q <= 1'b0;
          end
        end
        SERVICE: begin
          if (bus.eret) state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          ir_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ir_req  = ir_req_q;
  assign bus.ir_id   = ir_id_q;
  assign bus.pending = pending_q;
  assign bus.mask    = mask_q;
  assign bus.busy    = (state == REQ) || (state == SERVICE);

endmodule

// File: tb/tb_intr_ctrl.sv
// tb/tb_intr_ctrl.sv - self-checking bench for intr_ctrl
module tb_intr_ctrl;
`ifdef INTR_SYNC_EN
  localparam int PIPE = 1;
`else
  localparam int PIPE = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  intr_ctrl_if #(.N_IRQ(8)) bus ();

  intr_ctrl #(.N_IRQ(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    string      name;
    logic [7:0] irq;
    logic       mwe;
    logic [7:0] mwd;
    logic       cwe;
    logic [7:0] cd;
    logic       ack;
    logic       eret;
    int         n;
    bit         p;
    logic       req;
    logic [2:0] id;
    logic [7:0] pend;
    logic [7:0] msk;
    logic       busy;
  } vec_t;

  vec_t vt [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobes_off();
    bus.mask_we = 1'b0;
    bus.clr_we  = 1'b0;
    bus.clr_data = 8'h00;
    bus.ir_ack  = 1'b0;
    bus.eret    = 1'b0;
  endtask

  task automatic wait_req(input string name);
    int k;
    k = 0;
    while (bus.ir_req !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    chk({name, "_req_timeout"}, 32'(bus.ir_req), 32'd1);
  endtask

  task automatic chk_all(input string name, input logic req, input logic [2:0] id,
                         input logic [7:0] pend, input logic [7:0] msk, input logic busy);
    chk({name, "_req"},  32'(bus.ir_req),  32'(req));
    chk({name, "_id"},   32'(bus.ir_id),   32'(id));
    chk({name, "_pend"}, 32'(bus.pending), 32'(pend));
    chk({name, "_mask"}, 32'(bus.mask),    32'(msk));
    chk({name, "_busy"}, 32'(bus.busy),    32'(busy));
  endtask

  initial begin
    //          name   irq    mwe mwd    cwe cd     ack eret n  p  req id pend   msk    busy
    vt[0]  = '{"a_pend0",  8'h01, 0, 8'h00, 0, 8'h00, 0, 0, 2, 1, 0, 0, 8'h01, 8'h00, 0};
    vt[1]  = '{"b_mwr",    8'h00, 1, 8'h01, 0, 8'h00, 0, 0, 1, 0, 0, 0, 8'h01, 8'h01, 0};
    vt[2]  = '{"c_req0",   8'h00, 0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 1, 0, 8'h01, 8'h01, 1};
    vt[3]  = '{"d_ack0",   8'h00, 0, 8'h00, 0, 8'h00, 1, 0, 1, 0, 0, 0, 8'h00, 8'h01, 1};
    vt[4]  = '{"e_svc",    8'h24, 1, 8'hFF, 0, 8'h00, 0, 0, 2, 1, 0, 0, 8'h24, 8'hFF, 1};
    vt[5]  = '{"f_eret",   8'h00, 0, 8'h00, 0, 8'h00, 0, 1, 1, 0, 0, 0, 8'h24, 8'hFF, 0};
    vt[6]  = '{"g_req2",   8'h00, 0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 1, 2, 8'h24, 8'hFF, 1};
    vt[7]  = '{"h_ack2",   8'h00, 0, 8'h00, 0, 8'h00, 1, 0, 1, 0, 0, 2, 8'h20, 8'hFF, 1};
    vt[8]  = '{"i_eret",   8'h00, 0, 8'h00, 0, 8'h00, 0, 1, 1, 0, 0, 2, 8'h20, 8'hFF, 0};
    vt[9]  = '{"j_req5",   8'h00, 0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 1, 5, 8'h20, 8'hFF, 1};
    vt[10] = '{"k_mask5",  8'h00, 1, 8'hDF, 0, 8'h00, 0, 0, 1, 0, 1, 5, 8'h20, 8'hDF, 1};
    vt[11] = '{"l_drop",   8'h00, 0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 0, 5, 8'h20, 8'hDF, 0};
    vt[12] = '{"m_idle",   8'h00, 0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 0, 5, 8'h20, 8'hDF, 0};
    vt[13] = '{"n_clr",    8'h00, 0, 8'h00, 1, 8'h20, 0, 0, 1, 0, 0, 5, 8'h00, 8'hDF, 0};
    vt[14] = '{"o_req3",   8'h08, 0, 8'h00, 0, 8'h00, 0, 0, 3, 1, 1, 3, 8'h08, 8'hDF, 1};
    vt[15] = '{"p_ack3",   8'h08, 0, 8'h00, 0, 8'h00, 1, 0, 1, 0, 0, 3, 8'h00, 8'hDF, 1};
    vt[16] = '{"q_level",  8'h08, 0, 8'h00, 0, 8'h00, 0, 1, 3, 0, 0, 3, 8'h00, 8'hDF, 0};
    vt[17] = '{"r_quiet",  8'h00, 0, 8'h00, 0, 8'h00, 0, 0, 3, 1, 0, 3, 8'h00, 8'hDF, 0};

    bus.irq_in = 8'h00;
    bus.mask_wdata = 8'h00;
    strobes_off();
    rst = 1'b1;
    #1;
    chk_all("rst_async", 0, 0, 8'h00, 8'h00, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk_all("rst_rel", 0, 0, 8'h00, 8'h00, 0);

    for (int i = 0; i < 18; i++) begin
      bus.irq_in     = vt[i].irq;
      bus.mask_we    = vt[i].mwe;
      bus.mask_wdata = vt[i].mwd;
      bus.clr_we     = vt[i].cwe;
      bus.clr_data   = vt[i].cd;
      bus.ir_ack     = vt[i].ack;
      bus.eret       = vt[i].eret;
      tick();
      strobes_off();
      repeat (vt[i].n - 1 + (vt[i].p ? PIPE : 0)) tick();
      chk_all(vt[i].name, vt[i].req, vt[i].id, vt[i].pend, vt[i].msk, vt[i].busy);
    end

    // Exact edge-to-request latency with a one-cycle pulse on line 3
    bus.mask_we = 1'b1;
    bus.mask_wdata = 8'hFF;
    tick();
    strobes_off();
    bus.irq_in = 8'h08;
    for (int k = 1; k <= 3 + PIPE; k++) begin
      tick();
      bus.irq_in = 8'h00;
      chk($sformatf("lat_pend_k%0d", k), 32'(bus.pending), (k >= 2 + PIPE) ? 32'h08 : 32'h00);
      chk($sformatf("lat_req_k%0d", k), 32'(bus.ir_req), (k >= 3 + PIPE) ? 32'd1 : 32'd0);
    end
    chk("lat_id", 32'(bus.ir_id), 32'd3);
    bus.ir_ack = 1'b1;
    tick();
    strobes_off();
    bus.eret = 1'b1;
    tick();
    strobes_off();

    // New edge on line 4 collides with a software clear of bit 4 while in REQ
    bus.irq_in = 8'h10;
    tick();
    bus.irq_in = 8'h00;
    wait_req("col");
    chk("col_id", 32'(bus.ir_id), 32'd4);
    tick();
    bus.irq_in = 8'h10;
    repeat (1 + PIPE) tick();
    bus.clr_we = 1'b1;
    bus.clr_data = 8'h10;
    tick();
    strobes_off();
    chk("col_pend", 32'(bus.pending), 32'h10);
    chk("col_busy", 32'(bus.busy), 32'd1);
    tick();
    chk("col_hold_req", 32'(bus.ir_req), 32'd1);
    chk("col_hold_id", 32'(bus.ir_id), 32'd4);
    bus.irq_in = 8'h00;
    bus.clr_we = 1'b1;
    bus.clr_data = 8'h10;
    tick();
    strobes_off();
    chk("wd_pend", 32'(bus.pending), 32'h00);
    tick();
    chk("wd_req", 32'(bus.ir_req), 32'd0);
    chk("wd_busy", 32'(bus.busy), 32'd0);

    // Reset during SERVICE, with line 2 held high across release
    bus.irq_in = 8'h02;
    tick();
    bus.irq_in = 8'h00;
    wait_req("svc");
    bus.ir_ack = 1'b1;
    tick();
    strobes_off();
    chk("svc_busy", 32'(bus.busy), 32'd1);
    chk("svc_id", 32'(bus.ir_id), 32'd1);
    bus.irq_in = 8'h04;
    #2;
    rst = 1'b1;
    #1;
    chk_all("svc_rst", 0, 0, 8'h00, 8'h00, 0);
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("post_rst_req_%0d", k), 32'(bus.ir_req), 32'd0);
    end
    chk("post_rst_pend", 32'(bus.pending), 32'h04);
    bus.mask_we = 1'b1;
    bus.mask_wdata = 8'h04;
    tick();
    strobes_off();
    chk("unmask_req0", 32'(bus.ir_req), 32'd0);
    tick();
    chk("unmask_req1", 32'(bus.ir_req), 32'd1);
    chk("unmask_id", 32'(bus.ir_id), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/intr_ctrl.md
INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 SHALL have parameter N_IRQ, default 8, number of external interrupt lines (fixed at 8 for this block; ID width 3).
REQ-002 SHALL have clk  input  1  main clock, all state updates on the rising edge.
REQ-003 SHALL have rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have irq_in  input  8  raw external interrupt lines, rising-edge significant, asynchronous to clk.
REQ-005 SHALL have mask_we  input  1  write enable for the mask register.
REQ-006 SHALL have mask_wdata  input  8  new mask value; 1 = source enabled.
REQ-007 SHALL have clr_we  input  1  software pending-clear strobe.
REQ-008 SHALL have clr_data  input  8  pending bits to clear, written as 1s.
REQ-009 SHALL have ir_ack  input  1  one-cycle pulse from the CP0 stage when the interrupt jump is taken.
REQ-010 SHALL have eret  input  1  one-cycle pulse when ERET executes; ends service.
REQ-011 SHALL have ir_req  output  1  registered interrupt request, drives the CP0 ir_in.
REQ-012 SHALL have ir_id  output  3  index of the requesting source; valid while ir_req=1 and in SERVICE.
REQ-013 SHALL have pending  output  8  pending register, readable by the CP0 read path.
REQ-014 SHALL have mask  output  8  current mask register.
REQ-015 SHALL have busy  output  1  high in the REQ or SERVICE state.

Function
REQ-016 SHALL detect a rising edge on irq_in[i] as current sampled value 1 and previous sampled value 0; levels held high SHALL NOT re-trigger.
REQ-017 SHALL set pending[i] on the clock edge that detects a rising edge on line i.
REQ-018 SHALL clear pending[i] when clr_we=1 and clr_data[i]=1.
REQ-019 SHALL clear pending[ir_id] on the edge where ir_ack=1 in the REQ state.
REQ-020 SHALL let a set win over any clear when both target the same bit on the same edge.
REQ-021 SHALL form candidates = pending & mask and select the lowest-index set bit (bit 0 has highest priority).
REQ-022 SHALL implement the FSM with states IDLE, REQ and SERVICE.
REQ-023 IDLE: when candidates!=0, the FSM SHALL go to REQ, latch ir_id, and register ir_req=1 on the same edge.
REQ-024 REQ: ir_req and ir_id SHALL hold stable until ir_ack; on ir_ack the FSM SHALL go to SERVICE with ir_req=0 on that edge.
REQ-025 REQ: if the selected source becomes masked or cleared before ir_ack, the FSM SHALL return to IDLE with ir_req=0; it SHALL NOT re-arbitrate in the same cycle.
REQ-026 SERVICE: the FSM SHALL hold with no new request (no nesting) until eret, then go to IDLE; pending sources are serviced after that.
REQ-027 ir_ack outside REQ and eret outside SERVICE SHALL be ignored.
REQ-028 A mask_we write SHALL update mask on that edge, and arbitration SHALL see the new mask from the next cycle.
REQ-029 Edge-to-request latency SHALL be: edge at irq_in sampled at clock edge N -> pending set after N+2 -> ir_req=1 after N+3 (with synchronizer, IDLE, source unmasked).

Reset
REQ-030 On rst=1 the block SHALL immediately and asynchronously clear pending=0, mask=0, ir_req=0, ir_id=0, busy=0, all synchronizer/edge flops=0, and force FSM=IDLE.
REQ-031 A reset asserted mid-REQ or mid-SERVICE SHALL abort the request; no pulse SHALL occur on ir_req after release.
REQ-032 A line held high across reset release SHALL register one edge after release.

Configuration
REQ-033 SHALL provide macro INTR_SYNC_EN.
REQ-034 With INTR_SYNC_EN defined, each irq_in line SHALL pass through a 2-flop synchronizer before edge detection (latency per REQ-029).
REQ-035 Without INTR_SYNC_EN, irq_in SHALL feed edge detection through one flop only, and every latency SHALL shrink by exactly 1 cycle (ir_req after N+2).

Verification
REQ-036 mask=0xFF, pulse irq_in[3] at edge 10 -> pending=0x08 after edge 12, ir_req=1 and ir_id=3 after edge 13 (INTR_SYNC_EN on).
REQ-037 mask=0xFF, irq_in[5] and irq_in[2] rise on the same edge -> ir_id=2; ir_ack -> pending=0x20, SERVICE; eret -> ir_req=1 and ir_id=5 one cycle later.
REQ-038 mask=0x00, pulse irq_in[0] -> pending=0x01 and ir_req stays 0; write mask=0x01 -> ir_req=1 two edges after the write.
REQ-039 In REQ for id 4, clr_we=1 with clr_data=0x10 and a new irq_in[4] edge on the same edge -> pending[4]=1 and FSM stays in REQ.
REQ-040 Assert rst while in SERVICE -> all outputs 0 immediately; after release, ir_req stays 0 until a new unmasked edge occurs.
